fill_valve_arbiter: RTL and testbench
=====================================

FILL_VALVE_ARBITER -- requirements
Module: fill_valve_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of washer channels sharing one mains water inlet.
REQ-002 SHALL have parameter TW, default 16, meaning fill timer/limit width in bits.
REQ-003 SHALL have parameter GAP, default 2, meaning valve-settle idle cycles between grants (GAP >= 1).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N  per-washer fill request, level, held until filled or abandoned.
REQ-007 SHALL have port filled  input  N  per-washer level sensor, 1 = drum full.
REQ-008 SHALL have port fill_limit  input  TW  maximum fill cycles per grant; 0 = no timeout.
REQ-009 SHALL have port fault_clr  input  N  per-channel fault clear pulse.
REQ-010 SHALL have port gnt  output  N  registered one-hot grant (inlet routed to that washer).
REQ-011 SHALL have port valve_on  output  1  registered mains inlet valve drive.
REQ-012 SHALL have port fault  output  N  sticky per-channel fill-timeout flag.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, FILL, GAP; valve_on = 1 only in FILL; gnt = 0 outside FILL.
REQ-015 SHALL define eligible[i] = req[i] & ~fault[i] & ~filled[i].
REQ-016 SHALL, in IDLE with any eligible bit, select the first eligible channel at or after pointer ptr (round-robin, wrapping N-1 -> 0) and enter FILL on the next edge, with gnt = onehot(owner) and valve_on = 1 from that edge (one-cycle request-to-grant latency).
REQ-017 SHALL set ptr = (owner+1) mod N at each grant, so no channel is granted twice while another eligible channel waits.
REQ-018 SHALL load timer = 1 on entry to FILL and increment it each FILL cycle, saturating at all-ones.
REQ-019 SHALL leave FILL for GAP on the edge after any of: filled[owner] = 1 (complete), req[owner] = 0 (abandon), or fill_limit != 0 and timer == fill_limit (timeout).
REQ-020 SHALL set fault[owner] on timeout only; when filled[owner] and timeout coincide, complete wins and no fault is set.
REQ-021 SHALL hold GAP for exactly GAP cycles with gnt = 0 and valve_on = 0, then return to IDLE; requests arriving in FILL or GAP wait.
REQ-022 SHALL clear fault[i] on fault_clr[i] = 1; a same-cycle timeout set on channel i wins over its clear.
REQ-023 SHALL ignore req/filled changes of non-owner channels during FILL.
REQ-024 SHALL never assert more than one gnt bit, nor gnt with valve_on = 0.

Reset
REQ-025 SHALL, while rst = 0, force state = IDLE, gnt = 0, valve_on = 0, fault = 0, busy = 0, ptr = 0, timer = 0, asynchronously.
REQ-026 SHALL, on reset asserted mid-FILL, close the valve immediately and drop the grant without setting fault.
REQ-027 SHALL resume arbitration on the first rising edge after rst releases.

Verification
REQ-028 SHALL cover: req = 0001 in IDLE at cycle t -> gnt = 0001, valve_on = 1 at t+1; filled[0] = 1 at t+5 -> gnt = 0 at t+6, 2 GAP cycles, busy = 0 at t+8.
REQ-029 SHALL cover: req = 1111 held, filled pulsed per owner -> grant order 0,1,2,3,0 with ptr wrap.
REQ-030 SHALL cover: fill_limit = 10, filled never set -> exit after timer = 10, fault[owner] = 1, channel skipped until fault_clr pulsed.
REQ-031 SHALL cover: filled[owner] and timer == fill_limit on the same cycle -> no fault, normal completion.
REQ-032 SHALL cover: owner drops req mid-FILL -> GAP on next edge, no fault; fill_limit = 0 with 70000-cycle fill -> no timeout, timer saturates.
REQ-033 SHALL cover: rst = 0 mid-FILL -> gnt = 0, valve_on = 0 without a clock edge; after release req = 0010 -> gnt = 0010 one cycle later (ptr = 0 restart).

Source files
------------

// File: rtl/fill_valve_arbiter.sv
// Round-robin arbiter that routes one shared mains water inlet to N washer
// channels. Each grant opens the inlet valve for one washer until its drum is
// full, it abandons the request, or the optional fill timer expires (which
// marks a sticky fault). A fixed idle gap follows every grant so the valve can
// settle before the inlet is routed elsewhere.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-low reset
//   req        - per-washer fill request (level)
//   filled     - per-washer level sensor, 1 = drum full
//   fill_limit - maximum fill cycles per grant, 0 = no timeout
//   fault_clr  - per-channel fault clear pulse
//   gnt        - registered one-hot grant
//   valve_on   - registered mains inlet valve drive
//   fault      - sticky per-channel fill-timeout flags
//   busy       - high whenever the arbiter is not idle
module fill_valve_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned TW  = 16,
  parameter int unsigned GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  filled,
  input  logic [TW-1:0] fill_limit,
  input  logic [N-1:0]  fault_clr,
  output logic [N-1:0]  gnt,
  output logic          valve_on,
  output logic [N-1:0]  fault,
  output logic          busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;

  logic [N-1:0]    eligible;
  logic            found;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   sel_next_ptr;
  logic [N-1:0]    sel_onehot;
  logic [N-1:0]    owner_onehot;
  logic            owner_done;
  logic            owner_abandon;
  logic            timeout;
  logic            fill_exit;
  logic [N-1:0]    fault_set;

  assign eligible = req & ~fault & ~filled;

  // First eligible channel at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = ptr;
    idx   = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign sel_next_ptr = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);

  // One-hot decodes of the selected channel and the current owner.
  always_comb begin
    sel_onehot   = '0;
    owner_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      sel_onehot[i]   = (PW'(i) == sel);
      owner_onehot[i] = (PW'(i) == owner);
    end
  end

  // Exit conditions only look at the owner; other channels are ignored in FILL.
  assign owner_done    = filled[owner];
  assign owner_abandon = ~req[owner];
  assign timeout       = (fill_limit != '0) && (timer == fill_limit);
  assign fill_exit     = owner_done | owner_abandon | timeout;

  // A completion on the timeout cycle counts as a normal fill, not a fault.
  assign fault_set = ((state == S_FILL) && timeout && !owner_done) ? owner_onehot : '0;

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      valve_on <= 1'b0;
      fault    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      // Set is applied after clear so a same-cycle timeout wins.
      fault <= (fault & ~fault_clr) | fault_set;

      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_FILL;
            gnt      <= sel_onehot;
            valve_on <= 1'b1;
            busy     <= 1'b1;
            owner    <= sel;
            ptr      <= sel_next_ptr;
            timer    <= TW'(1);
          end
        end

        S_FILL: begin
          if (fill_exit) begin
            state    <= S_GAP;
            gnt      <= '0;
            valve_on <= 1'b0;
            gap_cnt  <= GW'(GAP - 1);
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          gnt      <= '0;
          valve_on <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Self-checking bench for fill_valve_arbiter. Expected grants are queued when
// requests are driven and compared by a monitor on each new grant; directed
// checks cover latency, gap timing, timeout faults and reset behaviour.
module tb_fill_valve_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  filled;
  logic [TW-1:0] fill_limit;
  logic [N-1:0]  fault_clr;
  logic [N-1:0]  gnt;
  logic          valve_on;
  logic [N-1:0]  fault;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] mon_exp;

  fill_valve_arbiter #(.N(N), .TW(TW), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .filled     (filled),
    .fill_limit (fill_limit),
    .fault_clr  (fault_clr),
    .gnt        (gnt),
    .valve_on   (valve_on),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) chk("wait_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (!busy) seen = 1'b1;
    end
    if (!seen) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Grant scoreboard plus per-cycle invariants.
  always @(negedge clk) begin
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_without_valve", 32'((|gnt) & ~valve_on), 32'd0);
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 32'(gnt), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("grant", 32'(gnt), 32'(mon_exp));
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    rst        = 1'b0;
    req        = '0;
    filled     = '0;
    fill_limit = '0;
    fault_clr  = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valve", 32'(valve_on), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    // Single request: latency, completion and gap timing.
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    chk("lat_gnt", 32'(gnt), 32'h1);
    chk("lat_valve", 32'(valve_on), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    filled = 4'b0001;
    tick();
    chk("done_gnt", 32'(gnt), 32'd0);
    chk("done_valve", 32'(valve_on), 32'd0);
    chk("gap1_busy", 32'(busy), 32'd1);
    req    = '0;
    filled = '0;
    tick();
    chk("gap2_busy", 32'(busy), 32'd1);
    tick();
    chk("gap_end_busy", 32'(busy), 32'd0);

    // Reset pointer, then round-robin over all four with wrap.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int r = 0; r < 4; r++) begin
      wait_gnt();
      tick();
      filled = gnt;
      tick();
      filled = '0;
    end
    wait_gnt();
    tick();
    req = '0;
    tick();
    chk("abandon_rr_gnt", 32'(gnt), 32'd0);
    wait_idle();

    // Timeout after ten fill cycles sets a fault on channel 2.
    fill_limit = TW'(10);
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    chk("to_gnt", 32'(gnt), 32'h4);
    repeat (9) tick();
    chk("to_held", 32'(gnt), 32'h4);
    tick();
    chk("to_exit_gnt", 32'(gnt), 32'd0);
    chk("to_fault", 32'(fault), 32'h4);
    req = 4'b1100;
    exp_q.push_back(4'b1000);
    wait_gnt();
    filled = 4'b1000;
    tick();
    filled = '0;
    req    = 4'b0100;
    wait_idle();
    repeat (5) tick();
    chk("faulted_skip_gnt", 32'(gnt), 32'd0);
    chk("faulted_skip_busy", 32'(busy), 32'd0);
    chk("fault_kept", 32'(fault), 32'h4);
    exp_q.push_back(4'b0100);
    fault_clr = 4'b0100;
    tick();
    fault_clr = '0;
    chk("fault_cleared", 32'(fault), 32'd0);
    wait_gnt();
    filled = 4'b0100;
    tick();
    filled = '0;
    req    = '0;
    wait_idle();

    // Completion on the same cycle the timer hits the limit: no fault.
    fill_limit = TW'(4);
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    repeat (3) tick();
    chk("coinc_held", 32'(gnt), 32'h1);
    filled = 4'b0001;
    tick();
    chk("coinc_gnt", 32'(gnt), 32'd0);
    chk("coinc_fault", 32'(fault), 32'd0);
    filled = '0;
    req    = '0;
    wait_idle();

    // Owner abandons mid-fill.
    fill_limit = '0;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_gnt();
    tick();
    tick();
    req = '0;
    tick();
    chk("abandon_gnt", 32'(gnt), 32'd0);
    chk("abandon_fault", 32'(fault), 32'd0);
    chk("abandon_busy", 32'(busy), 32'd1);
    wait_idle();

    // Long fill with no limit: no timeout, timer saturates.
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_gnt();
    repeat (70000) tick();
    chk("long_gnt", 32'(gnt), 32'h1);
    chk("long_fault", 32'(fault), 32'd0);
    chk("timer_sat", 32'(dut.timer), 32'hffff);
    filled = 4'b0001;
    tick();
    filled = '0;
    req    = '0;
    wait_idle();

    // Reset mid-fill closes the valve without a clock edge.
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_gnt();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_valve", 32'(valve_on), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_fault", 32'(fault), 32'd0);
    tick();
    rst = 1'b1;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    chk("restart_gnt", 32'(gnt), 32'h2);
    chk("restart_valve", 32'(valve_on), 32'd1);
    req = '0;
    wait_idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
